// File: rtl/snake_body_queue_ctrl.sv
// Snake-body circular-queue sequencer owning both ports of the body RAM.
// Build option: define SNAKE_COLLISION_CHECK_EN for the full-body self-collision scan.
module snake_body_queue_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic [DATA_W-1:0] move_head,
    input  logic              move_grow,
    output logic              result_valid,
    output logic              collide,
    output logic              tail_valid,
    output logic [DATA_W-1:0] tail_pos,
    output logic [ADDR_W:0]   length,
    output logic              full,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_d,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_q
);
    localparam logic [ADDR_W:0]   FULL_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   ONE_LEN  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        DRAIN,
        COMMIT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] head_ptr;
    logic [ADDR_W-1:0] tail_ptr;
    logic [ADDR_W:0]   scan_cnt;
    logic [DATA_W-1:0] head_p0;
    logic              grow_eff;
    logic              collide_r;
    logic              accept;
    logic              scan_last;
    logic              vld_p1;
    logic [ADDR_W:0]   idx_p1;
    logic              hit_p1;

    function automatic logic [ADDR_W-1:0] ring_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W:0]   offs);
        ring_addr = base + offs[ADDR_W-1:0];
    endfunction

`ifdef SNAKE_COLLISION_CHECK_EN
    // The tail cell only counts as a hit when it is kept (grow); otherwise it is vacated.
    function automatic logic body_hit(input logic [DATA_W-1:0] cell,
                                      input logic [DATA_W-1:0] head,
                                      input logic              is_tail,
                                      input logic              keep_tail);
        body_hit = (cell == head) && (!is_tail || keep_tail);
    endfunction

    assign scan_last = (scan_cnt == (length - ONE_LEN));
    assign hit_p1    = vld_p1 && body_hit(ram_q, head_p0, (idx_p1 == '0), grow_eff);
`else
    assign scan_last = 1'b1;
    assign hit_p1    = 1'b0;
`endif

    assign accept       = move_valid && (state == IDLE);
    assign full         = (length == FULL_LEN);
    assign collide      = collide_r;
    assign tail_valid   = (state == DONE) && !collide_r && !grow_eff;
    assign ram_d        = head_p0;
    assign ram_waddr    = head_ptr;
    assign ram_raddr    = ring_addr(tail_ptr, scan_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        move_ready   = 1'b0;
        result_valid = 1'b0;
        ram_we       = 1'b0;
        case (state)
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    state_next = (length == '0) ? COMMIT : SCAN;
                end
            end
            SCAN: begin
                if (scan_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN:  state_next = COMMIT;
            COMMIT: begin
                // Gated by reset so a write in flight is dropped in the reset cycle itself.
                ram_we     = !collide_r && !reset;
                state_next = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                state_next   = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Stage p0: move accept, read issue and queue update.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_ptr  <= '0;
            tail_ptr  <= '0;
            length    <= '0;
            grow_eff  <= 1'b0;
            collide_r <= 1'b0;
            tail_pos  <= '0;
            scan_cnt  <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= (state == SCAN);
            if (accept) begin
                grow_eff  <= (move_grow && !full) || (length == '0);
                collide_r <= 1'b0;
                scan_cnt  <= '0;
            end
            if (state == SCAN) begin
                scan_cnt <= scan_cnt + ONE_LEN;
            end
            // Stage p1: RAM data for the index issued one cycle earlier.
            if (vld_p1 && (idx_p1 == '0)) begin
                tail_pos <= ram_q;
            end
            if (hit_p1) begin
                collide_r <= 1'b1;
            end
            if ((state == COMMIT) && !collide_r) begin
                head_ptr <= head_ptr + ONE_PTR;
                if (grow_eff) begin
                    length <= length + ONE_LEN;
                end else begin
                    tail_ptr <= tail_ptr + ONE_PTR;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            head_p0 <= move_head;
        end
        idx_p1 <= scan_cnt;
    end

endmodule

// File: tb/tb_snake_body_queue_ctrl.sv
// Directed bench for snake_body_queue_ctrl with a behavioural body RAM and queue model.
module tb_snake_body_queue_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic       move_ready;
    logic [7:0] move_head;
    logic       move_grow;
    logic       result_valid;
    logic       collide;
    logic       tail_valid;
    logic [7:0] tail_pos;
    logic [8:0] length;
    logic       full;
    logic       ram_we;
    logic [7:0] ram_d;
    logic [7:0] ram_waddr;
    logic [7:0] ram_raddr;
    logic [7:0] ram_q;

    int checks = 0;
    int failures = 0;

    snake_body_queue_ctrl #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset(reset), .move_valid(move_valid), .move_ready(move_ready),
        .move_head(move_head), .move_grow(move_grow), .result_valid(result_valid),
        .collide(collide), .tail_valid(tail_valid), .tail_pos(tail_pos),
        .length(length), .full(full), .ram_we(ram_we), .ram_d(ram_d),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr), .ram_q(ram_q)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_d;
        ram_q <= mem[ram_raddr];
    end

    int         we_cnt = 0;
    logic [7:0] last_waddr = 8'h00;
    always @(posedge clk) begin
        if (ram_we) begin
            we_cnt     = we_cnt + 1;
            last_waddr = ram_waddr;
        end
    end

    // Reference queue model (used only for collision-free moves).
    logic [7:0] mq [256];
    int mh, mt, ml;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_move(input logic [7:0] h, input logic g,
                           output logic c, output logic tv, output logic [7:0] tp,
                           output int len, output int lat, output int wr,
                           output logic [7:0] wa);
        int n;
        int w0;
        n = 0;
        @(negedge clk);
        while (!move_ready && n < 600) begin
            @(negedge clk);
            n++;
        end
        move_valid = 1'b1;
        move_head  = h;
        move_grow  = g;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        w0  = we_cnt;
        lat = 1;
        while (!result_valid && lat < 600) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("result_valid", 32'(result_valid), 32'd1);
        c   = collide;
        tv  = tail_valid;
        tp  = tail_pos;
        len = int'(length);
        wr  = we_cnt - w0;
        wa  = last_waddr;
    endtask

    task automatic model_reset();
        mh = 0;
        mt = 0;
        ml = 0;
    endtask

    task automatic model_move(input logic [7:0] h, input logic g,
                              output logic etv, output logic [7:0] etp, output logic [7:0] ewa);
        logic ge;
        ge  = (g && ml < 256) || ml == 0;
        ewa = 8'(mh);
        etp = mq[mt];
        mq[mh] = h;
        mh = (mh + 1) % 256;
        if (ge) begin
            ml++;
            etv = 1'b0;
        end else begin
            mt = (mt + 1) % 256;
            etv = 1'b1;
        end
    endtask

    task automatic run_model_move(input logic [7:0] h, input logic g);
        logic c, tv, etv;
        logic [7:0] tp, wa, etp, ewa;
        int len, lat, wr;
        model_move(h, g, etv, etp, ewa);
        do_move(h, g, c, tv, tp, len, lat, wr, wa);
        check("model_collide", 32'(c), 32'd0);
        check("model_tail_valid", 32'(tv), 32'(etv));
        if (etv) check("model_tail_pos", 32'(tp), 32'(etp));
        check("model_length", 32'(len), 32'(ml));
        check("model_waddr", 32'(wa), 32'(ewa));
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [7:0] head;
        logic       grow;
        logic       exp_collide;
        logic       exp_tv;
        logic [7:0] exp_tp;
        int         exp_len;
        int         exp_lat;
        int         exp_writes;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic c, tv;
        logic [7:0] tp, wa;
        int len, lat, wr, w0;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
`ifdef SNAKE_COLLISION_CHECK_EN
        vecs[0] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1, 2, 1};
        vecs[1] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 2, 4, 1};
        vecs[2] = '{8'h13, 1'b1, 1'b0, 1'b0, 8'h00, 3, 5, 1};
        vecs[3] = '{8'h14, 1'b0, 1'b0, 1'b1, 8'h11, 3, 6, 1};
        vecs[4] = '{8'h13, 1'b0, 1'b1, 1'b0, 8'h00, 3, 6, 0};
        vecs[5] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'h12, 3, 6, 1};
`else
        vecs[0] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h00, 1, 2, 1};
        vecs[1] = '{8'h12, 1'b1, 1'b0, 1'b0, 8'h00, 2, 4, 1};
        vecs[2] = '{8'h13, 1'b1, 1'b0, 1'b0, 8'h00, 3, 4, 1};
        vecs[3] = '{8'h14, 1'b0, 1'b0, 1'b1, 8'h11, 3, 4, 1};
        vecs[4] = '{8'h13, 1'b0, 1'b0, 1'b1, 8'h12, 3, 4, 1};
        vecs[5] = '{8'h12, 1'b0, 1'b0, 1'b1, 8'h13, 3, 4, 1};
`endif
        reset      = 1'b1;
        move_valid = 1'b0;
        move_head  = 8'h00;
        move_grow  = 1'b0;
        apply_reset();

        check("rst_move_ready", 32'(move_ready), 32'd1);
        check("rst_length", 32'(length), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_collide", 32'(collide), 32'd0);
        check("rst_tail_valid", 32'(tail_valid), 32'd0);
        check("rst_tail_pos", 32'(tail_pos), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);

        foreach (vecs[i]) begin
            do_move(vecs[i].head, vecs[i].grow, c, tv, tp, len, lat, wr, wa);
            check($sformatf("v%0d_collide", i), 32'(c), 32'(vecs[i].exp_collide));
            check($sformatf("v%0d_tail_valid", i), 32'(tv), 32'(vecs[i].exp_tv));
            if (vecs[i].exp_tv) check($sformatf("v%0d_tail_pos", i), 32'(tp), 32'(vecs[i].exp_tp));
            check($sformatf("v%0d_length", i), 32'(len), 32'(vecs[i].exp_len));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_writes", i), 32'(wr), 32'(vecs[i].exp_writes));
        end
        check("ram0", 32'(mem[0]), 32'h11);
        check("ram1", 32'(mem[1]), 32'h12);
        check("ram2", 32'(mem[2]), 32'h13);
        check("ram3", 32'(mem[3]), 32'h14);
`ifdef SNAKE_COLLISION_CHECK_EN
        check("ram4", 32'(mem[4]), 32'h12);
`else
        check("ram4", 32'(mem[4]), 32'h13);
        check("ram5", 32'(mem[5]), 32'h12);
`endif

        // Fill the queue; codes start at 0x55 so a full-queue move onto the tail is legal.
        apply_reset();
        for (int i = 0; i < 256; i++) run_model_move(8'((8'h55 + i) & 8'hFF), 1'b1);
        check("fill_length", 32'(length), 32'd256);
        check("fill_full", 32'(full), 32'd1);
        do_move(8'h55, 1'b1, c, tv, tp, len, lat, wr, wa);
        check("fullgrow_collide", 32'(c), 32'd0);
        check("fullgrow_tail_valid", 32'(tv), 32'd1);
        check("fullgrow_tail_pos", 32'(tp), 32'h55);
        check("fullgrow_length", 32'(len), 32'd256);
        check("fullgrow_waddr", 32'(wa), 32'd0);
`ifdef SNAKE_COLLISION_CHECK_EN
        check("fullgrow_latency", 32'(lat), 32'd259);
`else
        check("fullgrow_latency", 32'(lat), 32'd4);
`endif
        check("fullgrow_full", 32'(full), 32'd1);
        mq[0] = 8'h55;
        mh = 1;
        mt = 1;
        for (int i = 0; i < 4; i++) run_model_move(mq[mt], 1'b0);

        // Pointer wrap with a short body so many moves stay cheap.
        apply_reset();
        run_model_move(8'hFE, 1'b1);
        run_model_move(8'hFF, 1'b1);
        for (int k = 0; k < 300; k++) run_model_move(8'(k & 255), 1'b0);

        // Reset while scanning: queue empties and the pending write never happens.
        apply_reset();
        run_model_move(8'h21, 1'b1);
        run_model_move(8'h22, 1'b1);
        run_model_move(8'h23, 1'b1);
        @(negedge clk);
        move_valid = 1'b1;
        move_head  = 8'h24;
        move_grow  = 1'b0;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        w0 = we_cnt;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst_move_ready", 32'(move_ready), 32'd1);
        check("midrst_length", 32'(length), 32'd0);
        check("midrst_ram_we", 32'(ram_we), 32'd0);
        check("midrst_result_valid", 32'(result_valid), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_write", 32'(we_cnt - w0), 32'd0);
        check("midrst_idle", 32'(move_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
